// File: rtl/chip8_audio_pkg.sv
// Shared types and constants for the CHIP-8 beeper sequencer and its sample strobe generator.
package chip8_audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CTRL_SINE     = 0;
  localparam int CTRL_FEEDBACK = 1;

  localparam int unsigned TICK_DIV_50M      = 833333;
  localparam int unsigned SAMPLE_DIV_50M    = 1042;
  localparam int unsigned TABLE_LEN_DEFAULT = 100;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_strobe_gen.sv
// Free-running codec sample counter producing registered sample_end / sample_req pulses.
module audio_strobe_gen
  import chip8_audio_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_50M
) (
  input  logic clk,
  input  logic reset_n,
  output logic sample_end,
  output logic sample_req
);

  localparam int unsigned CW = cnt_width(SAMPLE_DIV);

  if (SAMPLE_DIV < 3) begin : g_bad_div
    $error("audio_strobe_gen: SAMPLE_DIV must be >= 3");
  end

  logic [CW-1:0] r_samp_cnt;
  logic [CW-1:0] w_samp_nxt;

  always_comb begin
    w_samp_nxt = (r_samp_cnt == CW'(SAMPLE_DIV - 1)) ? '0 : r_samp_cnt + CW'(1);
  end

  // Strobes are decoded from the next count so they line up with the registered count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_samp_cnt <= '0;
      sample_end <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      r_samp_cnt <= w_samp_nxt;
      sample_end <= (w_samp_nxt == CW'(SAMPLE_DIV - 2));
      sample_req <= (w_samp_nxt == CW'(SAMPLE_DIV - 1));
    end
  end

endmodule

// File: rtl/chip8_beep_ctrl.sv
// CHIP-8 sound timer and beep sequencer; beep-off waits for a sine-period boundary.
module chip8_beep_ctrl
  import chip8_audio_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_50M,
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_50M,
  parameter int unsigned TABLE_LEN  = TABLE_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       st_we,
  input  logic [7:0] st_wdata,
  input  logic       feedback_en,
  output logic [7:0] st_value,
  output logic       sample_end,
  output logic       sample_req,
  output logic [1:0] control,
  output logic       busy
);

  localparam int unsigned TW = cnt_width(TICK_DIV);
  localparam int unsigned PW = cnt_width(TABLE_LEN);

  logic          w_sample_end;
  logic          w_sample_req;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [7:0]    w_nst;
  logic [PW-1:0] r_phase;
  logic          w_phase_inc;
  state_t        r_state;
  state_t        w_state_nxt;

  audio_strobe_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_strobe (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_end (w_sample_end),
    .sample_req (w_sample_req)
  );

  assign sample_end  = w_sample_end;
  assign sample_req  = w_sample_req;
  assign w_tick      = (r_tick_cnt == TW'(TICK_DIV - 1));
  // Only a pure sine output walks the ROM; feedback freezes the index.
  assign w_phase_inc = w_sample_req && (control == 2'b01);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_nst       = st_value;
    w_state_nxt = r_state;
    if (st_we) begin
      w_nst = st_wdata;
    end else if (w_tick && (st_value != 8'd0)) begin
      w_nst = st_value - 8'd1;
    end
    case (r_state)
      IDLE:    if (w_nst != 8'd0) w_state_nxt = PLAY;
      PLAY:    if (w_nst == 8'd0) w_state_nxt = DRAIN;
      DRAIN: begin
        if (w_nst != 8'd0) begin
          w_state_nxt = PLAY;
        end else if ((r_phase == '0) && !w_phase_inc) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
      r_phase    <= '0;
      r_state    <= IDLE;
      st_value   <= 8'd0;
      control    <= 2'b00;
      busy       <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      if (w_phase_inc) begin
        r_phase <= (r_phase == PW'(TABLE_LEN - 1)) ? '0 : r_phase + PW'(1);
      end
      r_state                <= w_state_nxt;
      st_value               <= w_nst;
      control[CTRL_FEEDBACK] <= feedback_en;
      control[CTRL_SINE]     <= (w_state_nxt != IDLE);
      busy                   <= (w_state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_chip8_beep_ctrl.sv
// Randomised bench for chip8_beep_ctrl against a cycle-count based behavioural model.
module tb_chip8_beep_ctrl;

  localparam int TD = 10;
  localparam int SD = 4;
  localparam int TL = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       st_we = 1'b0;
  logic [7:0] st_wdata = 8'd0;
  logic       feedback_en = 1'b0;
  logic [7:0] st_value;
  logic       sample_end;
  logic       sample_req;
  logic [1:0] control;
  logic       busy;

  int total = 0;
  int bad   = 0;

  chip8_beep_ctrl #(
    .TICK_DIV   (TD),
    .SAMPLE_DIV (SD),
    .TABLE_LEN  (TL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .st_we       (st_we),
    .st_wdata    (st_wdata),
    .feedback_en (feedback_en),
    .st_value    (st_value),
    .sample_end  (sample_end),
    .sample_req  (sample_req),
    .control     (control),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_cyc counts edges since reset, so strobes and ticks are plain modulo arithmetic.
  // A beep is active while the timer is nonzero, or until the sine index rests at 0.
  int         m_cyc   = 0;
  logic [7:0] m_st    = 8'd0;
  logic       m_busy  = 1'b0;
  int         m_phase = 0;
  logic [1:0] m_ctrl  = 2'b00;

  function automatic logic [7:0] f_nst();
    if (st_we) return st_wdata;
    if (((m_cyc % TD) == TD - 1) && (m_st != 8'd0)) return m_st - 8'd1;
    return m_st;
  endfunction

  function automatic logic f_adv();
    return ((m_cyc % SD) == SD - 1) && (m_ctrl == 2'b01);
  endfunction

  function automatic logic f_busy_nxt();
    return (f_nst() != 8'd0) || (m_st != 8'd0) || (m_busy && !((m_phase == 0) && !f_adv()));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cyc   <= 0;
      m_st    <= 8'd0;
      m_busy  <= 1'b0;
      m_phase <= 0;
      m_ctrl  <= 2'b00;
    end else begin
      m_cyc   <= m_cyc + 1;
      m_st    <= f_nst();
      m_phase <= f_adv() ? (m_phase + 1) % TL : m_phase;
      m_busy  <= f_busy_nxt();
      m_ctrl  <= {feedback_en, f_busy_nxt()};
    end
  end

  always @(negedge clk) begin
    check("st_value",   st_value,   m_st);
    check("control",    control,    m_ctrl);
    check("busy",       busy,       m_busy);
    check("sample_end", sample_end, (m_cyc % SD) == SD - 2);
    check("sample_req", sample_req, (m_cyc % SD) == SD - 1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step(1);
      n++;
    end
    check("drain_done", busy, 0);
  endtask

  task automatic wait_st_zero(input int budget);
    int n = 0;
    while (st_value !== 8'd0 && n < budget) begin
      step(1);
      n++;
    end
    check("timer_expired", st_value, 0);
  endtask

  initial begin
    step(2);
    reset_n = 1'b1;
    check("rst_st_value", st_value, 0);
    check("rst_control",  control,  0);
    check("rst_busy",     busy,     0);
    step(2);
    check("first_end",     sample_end, 1);
    check("first_end_req", sample_req, 0);
    step(1);
    check("first_req",     sample_req, 1);
    check("first_req_end", sample_end, 0);

    // Load 3, watch the first decrement at the tick, then the drain to idle.
    st_we = 1'b1; st_wdata = 8'd3;
    step(1);
    st_we = 1'b0;
    check("load3_st",   st_value, 3);
    check("load3_ctrl", control,  2'b01);
    check("load3_busy", busy,     1);
    step(6);
    check("first_tick_dec", st_value, 2);
    wait_idle(200);

    // Write in the same cycle as a tick: the write value wins.
    begin
      int n = 0;
      while ((m_cyc % TD) != 7 && n < 50) begin
        step(1);
        n++;
      end
    end
    st_we = 1'b1; st_wdata = 8'd2;
    step(1);
    st_we = 1'b0;
    step(1);
    check("pre_tick_st", st_value, 2);
    st_we = 1'b1; st_wdata = 8'd5;
    step(1);
    st_we = 1'b0;
    check("write_beats_tick", st_value, 5);

    // Reload while draining keeps the sine enabled.
    wait_st_zero(200);
    check("drain_entered", busy, 1);
    st_we = 1'b1; st_wdata = 8'd3;
    step(1);
    st_we = 1'b0;
    check("reload_busy", busy,     1);
    check("reload_ctrl", control,  2'b01);
    check("reload_st",   st_value, 3);
    wait_idle(200);

    // Feedback freezes the phase, so the drain holds until feedback drops.
    st_we = 1'b1; st_wdata = 8'd4;
    step(1);
    st_we = 1'b0;
    begin
      int n = 0;
      while (m_phase != 1 && n < 40) begin
        step(1);
        n++;
      end
    end
    feedback_en = 1'b1;
    step(1);
    check("fb_ctrl", control, 2'b11);
    wait_st_zero(100);
    step(20);
    check("fb_hold_busy", busy, 1);
    feedback_en = 1'b0;
    wait_idle(200);

    // Asynchronous reset in the middle of a beep.
    st_we = 1'b1; st_wdata = 8'd9;
    step(1);
    st_we = 1'b0;
    step(2);
    #1 reset_n = 1'b0;
    #1;
    check("arst_st",   st_value,   0);
    check("arst_ctrl", control,    0);
    check("arst_busy", busy,       0);
    check("arst_end",  sample_end, 0);
    check("arst_req",  sample_req, 0);
    step(1);
    reset_n = 1'b1;
    st_we = 1'b1; st_wdata = 8'd0;
    step(1);
    st_we = 1'b0;
    check("load0_busy", busy,    0);
    check("load0_ctrl", control, 2'b00);
    step(3);
    check("load0_stay_idle", busy, 0);

    // Random writes and feedback toggling, checked every cycle by the model.
    repeat (3000) begin
      st_we    = ($urandom_range(0, 39) == 0);
      st_wdata = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 149) == 0) feedback_en = ~feedback_en;
      step(1);
    end
    st_we = 1'b0;
    feedback_en = 1'b0;
    wait_idle(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
